demux_sequencer: RTL and testbench

DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux_sequencer.sv | 130 +++++++++++++
 tb/tb_demux_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the demux sequencer.
//   NCH     : number of downstream demux channels (bits per byte)
//   SEL_W   : width of the channel select
//   state_e : sequencer states
//   reorder : maps a byte to channel order so that channel k reads bit k
package demux_pkg;

   localparam int NCH   = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_e;

   // With msb_first set, channel k must carry data[7-k]; storing the byte
   // already reversed lets the shift stage always index by sel.
   function automatic logic [NCH-1:0] reorder(input logic [NCH-1:0] d,
                                              input logic           msb_first);
      logic [NCH-1:0] r;
      for (int k = 0; k < NCH; k++) begin
         r[k] = msb_first ? d[NCH-1-k] : d[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_sequencer.sv
// Serialises one byte per frame onto a 1-to-8 demux: 8 consecutive slots,
// sel counting 0..7, followed by IDLE_GAP idle cycles.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   data[7:0]  byte to distribute
//   valid      data/msb_first qualifier
//   msb_first  channel k gets data[7-k] when 1, data[k] when 0
//   ready      byte can be accepted this cycle
//   in         serial bit for the demux data input (registered)
//   sel[2:0]   demux channel select (registered)
//   active     in/sel carry a valid slot (registered)
//   last       pulse on the sel=7 slot (registered)
module demux_sequencer
   import demux_pkg::*;
#(
   parameter int IDLE_GAP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   data,
   input  logic             valid,
   input  logic             msb_first,
   output logic             ready,
   output logic             in,
   output logic [SEL_W-1:0] sel,
   output logic             active,
   output logic             last
);

   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);
   localparam logic [SEL_W-1:0] SEL_PRE  = SEL_W'(NCH - 2);
   // Loaded on entry to GAP; GAP exits when the counter reads zero.
   localparam logic [3:0]       GAP_LOAD = 4'(IDLE_GAP - 1);

   state_e           state_q,  state_d;
   logic [SEL_W-1:0] sel_q,    sel_d;
   logic [NCH-1:0]   cap_q,    cap_d;
   logic [3:0]       gap_q,    gap_d;
   logic             in_q,     in_d;
   logic             active_q, active_d;
   logic             last_q,   last_d;

   logic             accept;
   logic [NCH-1:0]   new_cap;

   // Back-to-back acceptance at sel=7 only exists without an idle gap.
   assign ready   = (state_q == IDLE) ||
                    ((state_q == SHIFT) && (sel_q == SEL_LAST) && (IDLE_GAP == 0));
   assign accept  = valid && ready;
   assign new_cap = reorder(data, msb_first);

   always_comb begin
      state_d  = state_q;
      sel_d    = '0;
      cap_d    = cap_q;
      gap_d    = gap_q;
      in_d     = 1'b0;
      active_d = 1'b0;
      last_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = SHIFT;
               cap_d    = new_cap;
               in_d     = new_cap[0];
               active_d = 1'b1;
            end
         end

         SHIFT: begin
            if (sel_q != SEL_LAST) begin
               // Outputs are registered, so precompute the next slot's bit.
               sel_d    = sel_q + 1'b1;
               in_d     = cap_q[sel_q + 1'b1];
               active_d = 1'b1;
               last_d   = (sel_q == SEL_PRE);
            end else if (accept) begin
               cap_d    = new_cap;
               in_d     = new_cap[0];
               active_d = 1'b1;
            end else if (IDLE_GAP == 0) begin
               state_d = IDLE;
            end else begin
               state_d = GAP;
               gap_d   = GAP_LOAD;
            end
         end

         GAP: begin
            if (gap_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         cap_q    <= '0;
         gap_q    <= '0;
         in_q     <= 1'b0;
         active_q <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cap_q    <= cap_d;
         gap_q    <= gap_d;
         in_q     <= in_d;
         active_q <= active_d;
         last_q   <= last_d;
      end
   end

   assign in     = in_q;
   assign sel    = sel_q;
   assign active = active_q;
   assign last   = last_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer: one instance with IDLE_GAP=0 (dut0)
// and one with IDLE_GAP=3 (dut3) sharing all inputs. Inputs change and
// outputs are sampled on the falling edge.
module tb_demux_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic       msb_first;

   logic       ready0, in0, active0, last0;
   logic [2:0] sel0;
   logic       ready3, in3, active3, last3;
   logic [2:0] sel3;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] recon;

   always #5 clk = ~clk;

   demux_sequencer #(.IDLE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .msb_first(msb_first),
      .ready(ready0), .in(in0), .sel(sel0), .active(active0), .last(last0)
   );

   demux_sequencer #(.IDLE_GAP(3)) dut3 (
      .clk(clk), .rst(rst), .data(data), .valid(valid), .msb_first(msb_first),
      .ready(ready3), .in(in3), .sel(sel3), .active(active3), .last(last3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame through both instances; exp_slot[k] is the hand-computed bit
   // for slot k. Caller is at a falling edge with both instances idle.
   task automatic run_frame(input string name, input logic [7:0] d, input logic m,
                            input logic [7:0] exp_slot, input logic [7:0] exp_recon,
                            input bit toggle);
      data = d; msb_first = m; valid = 1'b1;
      recon = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("%s act0 k%0d", name, k), 32'(active0), 32'd1);
         chk($sformatf("%s sel0 k%0d", name, k), 32'(sel0), 32'(k));
         chk($sformatf("%s in0 k%0d", name, k), 32'(in0), 32'(exp_slot[k]));
         chk($sformatf("%s last0 k%0d", name, k), 32'(last0), 32'(k == 7));
         chk($sformatf("%s rdy0 k%0d", name, k), 32'(ready0), 32'(k == 7));
         chk($sformatf("%s in3 k%0d", name, k), 32'(in3), 32'(exp_slot[k]));
         chk($sformatf("%s rdy3 k%0d", name, k), 32'(ready3), 32'd0);
         if (active0) recon[sel0] = in0;
         valid = 1'b0;
         if (toggle) begin
            data = ~data;
            msb_first = ~msb_first;
         end
      end
      @(negedge clk);
      chk({name, " act0 after"}, 32'(active0), 32'd0);
      chk({name, " last0 after"}, 32'(last0), 32'd0);
      chk({name, " rdy0 after"}, 32'(ready0), 32'd1);
      chk({name, " act3 gap"}, 32'(active3), 32'd0);
      chk({name, " rdy3 gap"}, 32'(ready3), 32'd0);
      chk({name, " recon"}, 32'(recon), 32'(exp_recon));
      $display("frame %s data=%02h msb_first=%0b recon=%02h", name, d, m, recon);
      repeat (3) @(negedge clk);
      chk({name, " rdy3 idle"}, 32'(ready3), 32'd1);
   endtask

   initial begin
      rst = 1'b1; data = 8'h00; valid = 1'b0; msb_first = 1'b0;
      recon = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst act0", 32'(active0), 32'd0);
      chk("rst sel0", 32'(sel0), 32'd0);
      chk("rst in0", 32'(in0), 32'd0);
      chk("rst last0", 32'(last0), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst rdy0", 32'(ready0), 32'd1);
      chk("post-rst rdy3", 32'(ready3), 32'd1);
      $display("reset check done");

      // LSB-first A5, MSB-first 01, stability with toggling inputs on 3C
      run_frame("lsb_a5", 8'hA5, 1'b0, 8'b1010_0101, 8'hA5, 1'b0);
      run_frame("msb_01", 8'h01, 1'b1, 8'b1000_0000, 8'h80, 1'b0);
      run_frame("stab_3c", 8'h3C, 1'b0, 8'b0011_1100, 8'h3C, 1'b1);

      // Back-to-back on dut0: FF then 00 with valid held high
      data = 8'hFF; msb_first = 1'b0; valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk($sformatf("b2b act0 k%0d", k), 32'(active0), 32'd1);
         chk($sformatf("b2b sel0 k%0d", k), 32'(sel0), 32'(k % 8));
         chk($sformatf("b2b in0 k%0d", k), 32'(in0), 32'(k < 8));
         chk($sformatf("b2b rdy0 k%0d", k), 32'(ready0), 32'((k % 8) == 7));
         chk($sformatf("b2b last0 k%0d", k), 32'(last0), 32'((k % 8) == 7));
         if (k == 0) data = 8'h00;
         if (k == 15) valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b act0 end", 32'(active0), 32'd0);
      $display("back-to-back frames FF,00 done");
      repeat (20) @(negedge clk);

      // Gap on dut3 with valid held high: period 12
      data = 8'h5A; msb_first = 1'b0; valid = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c <= 8) begin
            chk($sformatf("gap act3 c%0d", c), 32'(active3), 32'd1);
            chk($sformatf("gap sel3 c%0d", c), 32'(sel3), 32'(c - 1));
         end else if (c <= 11) begin
            chk($sformatf("gap act3 c%0d", c), 32'(active3), 32'd0);
            chk($sformatf("gap rdy3 c%0d", c), 32'(ready3), 32'd0);
         end else if (c == 12) begin
            chk("gap act3 idle", 32'(active3), 32'd0);
            chk("gap rdy3 idle", 32'(ready3), 32'd1);
         end else begin
            chk("gap act3 next", 32'(active3), 32'd1);
            chk("gap sel3 next", 32'(sel3), 32'd0);
            valid = 1'b0;
         end
      end
      $display("gap frame period check done");
      repeat (24) @(negedge clk);

      // Reset in mid-SHIFT at sel=4, held 2 cycles with valid high
      data = 8'hFF; msb_first = 1'b0; valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         valid = 1'b0;
      end
      chk("mid sel0", 32'(sel0), 32'd4);
      rst = 1'b1; valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("mrst act0 %0d", k), 32'(active0), 32'd0);
         chk($sformatf("mrst sel0 %0d", k), 32'(sel0), 32'd0);
         chk($sformatf("mrst last0 %0d", k), 32'(last0), 32'd0);
         chk($sformatf("mrst act3 %0d", k), 32'(active3), 32'd0);
      end
      rst = 1'b0; valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("prst act0 %0d", k), 32'(active0), 32'd0);
         chk($sformatf("prst last0 %0d", k), 32'(last0), 32'd0);
         chk($sformatf("prst rdy0 %0d", k), 32'(ready0), 32'd1);
         chk($sformatf("prst rdy3 %0d", k), 32'(ready3), 32'd1);
      end
      $display("mid-frame reset check done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
